reg_writeback_arbiter: RTL and testbench

Write-back stage directly upstream of the 8 x 16 register file. It drives that file's single write port (W_Adr, we, W). It merges two result sources:
- ALU results: every cycle, no backpressure.
- Memory-load results: valid/ready handshake.

Load results that cannot be written immediately are queued in an in-order FIFO. The block also reports pending-write status to the control unit.

---
 rtl/reg_writeback_arbiter.sv | 121 ++++++++++++
 tb/tb_reg_writeback_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_arbiter.sv
// Write-back arbiter feeding the register file's single write port: ALU results win,
// memory loads bypass or queue in an in-order FIFO. Optional forwarding via WB_FORWARD_EN.
module reg_writeback_arbiter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 3,
   parameter int unsigned DW    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alu_valid,
   input  logic [AW-1:0]              alu_adr,
   input  logic [DW-1:0]              alu_data,
   input  logic                       mem_valid,
   output logic                       mem_ready,
   input  logic [AW-1:0]              mem_adr,
   input  logic [DW-1:0]              mem_data,
   output logic [AW-1:0]              W_Adr,
   output logic                       we,
   output logic [DW-1:0]              W,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       wb_busy
`ifdef WB_FORWARD_EN
   ,
   input  logic [AW-1:0]              fwd_r_adr,
   input  logic [AW-1:0]              fwd_s_adr,
   output logic                       fwd_r_hit,
   output logic [DW-1:0]              fwd_r_data,
   output logic                       fwd_s_hit,
   output logic [DW-1:0]              fwd_s_data
`endif
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [AW-1:0] adr;
      logic [DW-1:0] data;
   } wb_entry_t;

   wb_entry_t         fifo_mem [DEPTH];
   logic [PW-1:0]     rd_ptr, rd_ptr_n;
   logic [PW-1:0]     wr_ptr, wr_ptr_n;
   logic [CW-1:0]     count, count_n;
   logic              we_n;
   wb_entry_t         stage, stage_n;
   wb_entry_t         alu_entry, mem_entry;
   logic              accept, pop, bypass, push;

   assign alu_entry  = '{adr: alu_adr, data: alu_data};
   assign mem_entry  = '{adr: mem_adr, data: mem_data};

   assign mem_ready  = !rst && (count < CW'(DEPTH));
   assign fifo_count = count;
   assign wb_busy    = we || (count != '0);
   assign W_Adr      = stage.adr;
   assign W          = stage.data;

   // Priority: ALU, then FIFO head, then a freshly accepted load straight through.
   always_comb begin
      accept   = mem_valid && mem_ready;
      pop      = !alu_valid && (count != '0);
      bypass   = !alu_valid && (count == '0) && accept;
      push     = accept && !bypass;
      we_n     = 1'b0;
      stage_n  = stage;
      rd_ptr_n = rd_ptr;
      wr_ptr_n = wr_ptr;
      count_n  = count;

      if (alu_valid) begin
         we_n    = 1'b1;
         stage_n = alu_entry;
      end else if (pop) begin
         we_n    = 1'b1;
         stage_n = fifo_mem[rd_ptr];
      end else if (bypass) begin
         we_n    = 1'b1;
         stage_n = mem_entry;
      end

      if (pop)  rd_ptr_n = rd_ptr + PW'(1);
      if (push) wr_ptr_n = wr_ptr + PW'(1);

      case ({push, pop})
         2'b10:   count_n = count + CW'(1);
         2'b01:   count_n = count - CW'(1);
         default: count_n = count;
      endcase
   end

   // Write stage, pointers and occupancy; reset drops anything queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         we     <= 1'b0;
         stage  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         we     <= we_n;
         stage  <= stage_n;
         rd_ptr <= rd_ptr_n;
         wr_ptr <= wr_ptr_n;
         count  <= count_n;
      end
   end

   // Payload storage carries no reset; validity comes from count alone.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_entry;
   end

`ifdef WB_FORWARD_EN
   assign fwd_r_hit  = we && (W_Adr == fwd_r_adr);
   assign fwd_r_data = fwd_r_hit ? W : '0;
   assign fwd_s_hit  = we && (W_Adr == fwd_s_adr);
   assign fwd_s_data = fwd_s_hit ? W : '0;
`endif

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Scoreboard bench for reg_writeback_arbiter: expected writes queued in order,
// a negedge monitor pops and compares every cycle the DUT presents we.
module tb_reg_writeback_arbiter;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid;
   logic [AW-1:0] alu_adr;
   logic [DW-1:0] alu_data;
   logic          mem_valid;
   logic          mem_ready;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_data;
   logic [AW-1:0] W_Adr;
   logic          we;
   logic [DW-1:0] W;
   logic [2:0]    fifo_count;
   logic          wb_busy;

   int checks   = 0;
   int failures = 0;
   logic [AW+DW-1:0] exp_q[$];

   reg_writeback_arbiter #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_adr(alu_adr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_adr(mem_adr), .mem_data(mem_data),
      .W_Adr(W_Adr), .we(we), .W(W), .fifo_count(fifo_count), .wb_busy(wb_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_q.push_back({a, d});
   endtask

   // Apply inputs, let one rising edge pass, return #1 after it.
   task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
      alu_valid = av; alu_adr = aa; alu_data = ad;
      mem_valid = mv; mem_adr = ma; mem_data = md;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   // Monitor: every presented write must match the next scoreboard entry.
   initial begin
      forever begin
         @(negedge clk);
         if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {13'd0, W_Adr, W}, 32'hFFFF_FFFF);
            end else begin
               logic [AW+DW-1:0] e;
               e = exp_q.pop_front();
               chk("wr_adr", 32'(W_Adr), 32'(e[AW+DW-1:DW]));
               chk("wr_data", 32'(W), 32'(e[DW-1:0]));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      alu_valid = 1'b0; alu_adr = '0; alu_data = '0;
      mem_valid = 1'b0; mem_adr = '0; mem_data = '0;
      @(posedge clk); #1;
      chk("ready_in_reset", 32'(mem_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #0;
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_wadr", 32'(W_Adr), 32'd0);
      chk("rst_w", 32'(W), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_busy", 32'(wb_busy), 32'd0);
      chk("rst_ready", 32'(mem_ready), 32'd1);

      // ALU only
      expect_wr(3'd3, 16'hA5A5);
      step(1'b1, 3'd3, 16'hA5A5, 1'b0, '0, '0);
      chk("alu_we", 32'(we), 32'd1);
      idle();
      chk("alu_we_drop", 32'(we), 32'd0);

      // Load bypass
      expect_wr(3'd5, 16'h1234);
      step(1'b0, '0, '0, 1'b1, 3'd5, 16'h1234);
      chk("bypass_we", 32'(we), 32'd1);
      chk("bypass_count", 32'(fifo_count), 32'd0);
      idle();

      // Collision: ALU first, load second to the same register
      expect_wr(3'd2, 16'h1111);
      expect_wr(3'd2, 16'h2222);
      step(1'b1, 3'd2, 16'h1111, 1'b1, 3'd2, 16'h2222);
      chk("coll_count1", 32'(fifo_count), 32'd1);
      idle();
      chk("coll_count0", 32'(fifo_count), 32'd0);
      chk("coll_final_w", 32'(W), 32'h2222);
      idle();

      // Fill and backpressure
      for (int i = 0; i < 6; i++) expect_wr(3'(i), 16'hC000 + 16'(i));
      for (int i = 1; i <= 6; i++) expect_wr(3'(i), 16'(i));
      for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 16'hC000 + 16'(i), 1'b1, 3'(i + 1), 16'(i + 1));
      chk("fill_count4", 32'(fifo_count), 32'd4);
      chk("fill_ready0", 32'(mem_ready), 32'd0);
      chk("fill_busy", 32'(wb_busy), 32'd1);
      for (int i = 4; i < 6; i++) step(1'b1, 3'(i), 16'hC000 + 16'(i), 1'b1, 3'd5, 16'd5);
      chk("stall_count4", 32'(fifo_count), 32'd4);
      alu_valid = 1'b0;
      #0;
      chk("pop_cycle_ready0", 32'(mem_ready), 32'd0);
      step(1'b0, '0, '0, 1'b1, 3'd5, 16'd5);
      chk("after_pop_count3", 32'(fifo_count), 32'd3);
      chk("after_pop_ready1", 32'(mem_ready), 32'd1);
      step(1'b0, '0, '0, 1'b1, 3'd5, 16'd5);
      chk("push5_count3", 32'(fifo_count), 32'd3);
      step(1'b0, '0, '0, 1'b1, 3'd6, 16'd6);
      chk("push6_count3", 32'(fifo_count), 32'd3);
      for (int i = 0; i < 3; i++) idle();
      chk("drain_count0", 32'(fifo_count), 32'd0);
      idle();
      chk("drain_busy0", 32'(wb_busy), 32'd0);

      // Reset mid-drain: three queued loads are discarded
      for (int i = 0; i < 3; i++) begin
         expect_wr(3'd7, 16'hD000 + 16'(i));
         step(1'b1, 3'd7, 16'hD000 + 16'(i), 1'b1, 3'(i), 16'hBAD0 + 16'(i));
      end
      chk("pre_rst_count3", 32'(fifo_count), 32'd3);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      #0;
      chk("mid_rst_count0", 32'(fifo_count), 32'd0);
      chk("mid_rst_we0", 32'(we), 32'd0);
      for (int i = 0; i < 5; i++) idle();
      chk("post_rst_we0", 32'(we), 32'd0);

      // Bounded wait for the scoreboard to drain
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
